windowed_register_file: RTL and testbench

Parametrised SPARC-style windowed integer register file, successor to the flat three-read-port register file. It keeps three combinational read ports and one write port. It adds overlapping register windows, a current window pointer (CWP) advanced by SAVE/RESTORE, a window invalid mask (WIM), and overflow/underflow trap pulses. It sits in the decode/operand stage of the pipeline, feeding the ALU and store-data path.

---
 rtl/rf_window_pkg.sv | 32 +++
 rtl/window_reg_map.sv | 15 +
 rtl/windowed_register_file.sv | 104 ++++++++++
 tb/tb_windowed_register_file.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rf_window_pkg.sv
// Shared constants and the logical-to-physical mapping for the windowed register file.
package rf_window_pkg;

   // Logical register group bases within a window
   localparam int unsigned GLOBAL_BASE = 0;
   localparam int unsigned OUT_BASE    = 8;
   localparam int unsigned LOCAL_BASE  = 16;
   localparam int unsigned IN_BASE     = 24;

   // Physical distance between adjacent windows: outs plus locals (ins overlap the next window's outs)
   localparam int unsigned WIN_STRIDE = (LOCAL_BASE - OUT_BASE) + (IN_BASE - LOCAL_BASE);

   // Globals map straight through; windowed registers wrap modulo the windowed storage size.
   // 16*cwp + (logical-8) never reaches twice the windowed size, so one conditional subtract suffices.
   function automatic int unsigned phys_index(input int unsigned logical,
                                              input int unsigned cwp,
                                              input int unsigned nwindows);
      int unsigned rel;
      int unsigned result;
      if (logical < OUT_BASE) begin
         result = GLOBAL_BASE + logical;
      end else begin
         rel = WIN_STRIDE * cwp + (logical - OUT_BASE);
         if (rel >= WIN_STRIDE * nwindows) begin
            rel = rel - WIN_STRIDE * nwindows;
         end
         result = OUT_BASE + rel;
      end
      return result;
   endfunction

endpackage

// File: rtl/window_reg_map.sv
// Combinational translator from a logical register select to a physical storage index.
module window_reg_map #(
   parameter int NWINDOWS = 4
) (
   input  logic [4:0]                               logical_i,
   input  logic [$clog2(NWINDOWS)-1:0]              cwp_i,
   output logic [$clog2(8 + 16*NWINDOWS)-1:0]       phys_o
);
   import rf_window_pkg::*;

   localparam int PIDX_W = $clog2(8 + 16*NWINDOWS);

   assign phys_o = PIDX_W'(phys_index(32'(logical_i), 32'(cwp_i), NWINDOWS));

endmodule

// File: rtl/windowed_register_file.sv
// Windowed integer register file: three combinational read ports, one write port,
// CWP/WIM window control with registered overflow/underflow trap pulses.
module windowed_register_file #(
   parameter int WIDTH    = 32,
   parameter int NWINDOWS = 4,
   parameter int BYPASS   = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [4:0]                  RA,
   input  logic [4:0]                  RB,
   input  logic [4:0]                  RD,
   output logic [WIDTH-1:0]            PA,
   output logic [WIDTH-1:0]            PB,
   output logic [WIDTH-1:0]            PD,
   input  logic [4:0]                  RW,
   input  logic [WIDTH-1:0]            PW,
   input  logic                        LE,
   input  logic                        save,
   input  logic                        restore,
   input  logic                        wim_we,
   input  logic [NWINDOWS-1:0]         wim_in,
   output logic [$clog2(NWINDOWS)-1:0] cwp,
   output logic [NWINDOWS-1:0]         wim,
   output logic                        ovf_trap,
   output logic                        unf_trap
);
   import rf_window_pkg::*;

   localparam int CW     = $clog2(NWINDOWS);
   localparam int NPHYS  = 8 + 16*NWINDOWS;
   localparam int PIDX_W = $clog2(NPHYS);

   logic [WIDTH-1:0]    regs_q [NPHYS];
   logic [CW-1:0]       cwp_q, cwp_d;
   logic [NWINDOWS-1:0] wim_q, wim_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic [CW-1:0]       save_tgt, rest_tgt;
   logic [PIDX_W-1:0]   pa_idx, pb_idx, pd_idx, pw_idx;
   logic                wr_fwd;
   logic                wr_en;

   window_reg_map #(.NWINDOWS(NWINDOWS)) u_map_a (.logical_i(RA), .cwp_i(cwp_q), .phys_o(pa_idx));
   window_reg_map #(.NWINDOWS(NWINDOWS)) u_map_b (.logical_i(RB), .cwp_i(cwp_q), .phys_o(pb_idx));
   window_reg_map #(.NWINDOWS(NWINDOWS)) u_map_d (.logical_i(RD), .cwp_i(cwp_q), .phys_o(pd_idx));
   window_reg_map #(.NWINDOWS(NWINDOWS)) u_map_w (.logical_i(RW), .cwp_i(cwp_q), .phys_o(pw_idx));

   // r0 is hard-wired to zero, so writes to it are dropped and never forwarded
   assign wr_en  = LE && (RW != 5'd0);
   assign wr_fwd = (BYPASS != 0) && wr_en;

   assign PA = (RA == 5'd0) ? '0 : (wr_fwd && (RW == RA)) ? PW : regs_q[pa_idx];
   assign PB = (RB == 5'd0) ? '0 : (wr_fwd && (RW == RB)) ? PW : regs_q[pb_idx];
   assign PD = (RD == 5'd0) ? '0 : (wr_fwd && (RW == RD)) ? PW : regs_q[pd_idx];

   assign save_tgt = (cwp_q == '0) ? CW'(NWINDOWS-1) : cwp_q - 1'b1;
   assign rest_tgt = (cwp_q == CW'(NWINDOWS-1)) ? '0 : cwp_q + 1'b1;

   // Window movement and trap decision; checks use the WIM value held before this edge
   always_comb begin
      cwp_d = cwp_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      wim_d = wim_we ? wim_in : wim_q;
      if (save && !restore) begin
         if (wim_q[save_tgt]) ovf_d = 1'b1;
         else                 cwp_d = save_tgt;
      end else if (restore && !save) begin
         if (wim_q[rest_tgt]) unf_d = 1'b1;
         else                 cwp_d = rest_tgt;
      end
   end

   // Control state: CWP, WIM and the one-cycle trap pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cwp_q <= '0;
         wim_q <= {1'b1, {(NWINDOWS-1){1'b0}}};
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         cwp_q <= cwp_d;
         wim_q <= wim_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Register storage; the write index is resolved under the CWP in effect before the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NPHYS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[pw_idx] <= PW;
      end
   end

   assign cwp      = cwp_q;
   assign wim      = wim_q;
   assign ovf_trap = ovf_q;
   assign unf_trap = unf_q;

endmodule

// File: tb/tb_windowed_register_file.sv
// Directed self-checking bench for windowed_register_file (WIDTH=32, NWINDOWS=4, BYPASS=1).
module tb_windowed_register_file;

   logic        clk;
   logic        rst_n;
   logic [4:0]  RA, RB, RD, RW;
   logic [31:0] PA, PB, PD, PW;
   logic        LE, save, restore, wim_we;
   logic [3:0]  wim_in;
   logic [1:0]  cwp;
   logic [3:0]  wim;
   logic        ovf_trap, unf_trap;

   int checks;
   int failures;

   windowed_register_file #(.WIDTH(32), .NWINDOWS(4), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .RA(RA), .RB(RB), .RD(RD),
      .PA(PA), .PB(PB), .PD(PD),
      .RW(RW), .PW(PW), .LE(LE),
      .save(save), .restore(restore),
      .wim_we(wim_we), .wim_in(wim_in),
      .cwp(cwp), .wim(wim),
      .ovf_trap(ovf_trap), .unf_trap(unf_trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0;
      RA = '0; RB = '0; RD = '0; RW = '0; PW = '0;
      LE = 1'b0; save = 1'b0; restore = 1'b0; wim_we = 1'b0; wim_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Reset state
      RA = 5'd0; RB = 5'd8; RD = 5'd31; #1;
      check("rst_r0", PA, 0);
      check("rst_r8", PB, 0);
      check("rst_r31", PD, 0);
      check("rst_cwp", cwp, 0);
      check("rst_wim", wim, 4'b1000);
      check("rst_ovf", ovf_trap, 0);
      check("rst_unf", unf_trap, 0);

      // Open windows 0 and 3 for the data tests
      wim_we = 1'b1; wim_in = 4'b0010; tick(); wim_we = 1'b0;
      check("wim_load", wim, 4'b0010);

      // Locals are per-window, globals shared
      LE = 1'b1; RW = 5'd16; PW = 32'd20; tick();
      RW = 5'd7; PW = 32'd7; tick();
      LE = 1'b0; save = 1'b1; tick(); save = 1'b0;
      check("save_cwp", cwp, 3);
      RA = 5'd16; RB = 5'd7; #1;
      check("w3_r16", PA, 0);
      check("w3_r7", PB, 7);
      restore = 1'b1; tick(); restore = 1'b0;
      check("rest_cwp", cwp, 0);
      check("w0_r16", PA, 20);

      // Overlap: outs of window 0 are ins of window 3 and vice versa
      LE = 1'b1; RW = 5'd8; PW = 32'h55; tick();
      LE = 1'b0; save = 1'b1; tick(); save = 1'b0;
      RA = 5'd24; #1;
      check("ovl_cwp3", cwp, 3);
      check("ovl_r24", PA, 32'h55);
      LE = 1'b1; RW = 5'd25; PW = 32'h66; tick();
      LE = 1'b0; restore = 1'b1; tick(); restore = 1'b0;
      RA = 5'd9; #1;
      check("ovl_cwp0", cwp, 0);
      check("ovl_r9", PA, 32'h66);

      // Write concurrent with SAVE lands in the old window
      LE = 1'b1; RW = 5'd17; PW = 32'h77; save = 1'b1; tick();
      LE = 1'b0; save = 1'b0;
      RA = 5'd17; #1;
      check("wsave_cwp", cwp, 3);
      check("wsave_new", PA, 0);
      restore = 1'b1; tick(); restore = 1'b0;
      check("wsave_old", PA, 32'h77);

      // Overflow with the default WIM, back-to-back pulses
      wim_we = 1'b1; wim_in = 4'b1000; tick(); wim_we = 1'b0;
      save = 1'b1; tick();
      check("ovf1_cwp", cwp, 0);
      check("ovf1", ovf_trap, 1);
      tick(); save = 1'b0;
      check("ovf2", ovf_trap, 1);
      tick();
      check("ovf_clr", ovf_trap, 0);
      check("ovf_cwp", cwp, 0);

      wim_we = 1'b1; wim_in = 4'b0100; tick(); wim_we = 1'b0;
      save = 1'b1; tick(); save = 1'b0;
      check("save_ok_cwp", cwp, 3);
      check("save_ok_ovf", ovf_trap, 0);

      // Underflow
      wim_we = 1'b1; wim_in = 4'b0001; tick(); wim_we = 1'b0;
      restore = 1'b1; tick(); restore = 1'b0;
      check("unf_pulse", unf_trap, 1);
      check("unf_cwp", cwp, 3);
      tick();
      check("unf_clr", unf_trap, 0);

      // Same-cycle WIM load: trap decision uses the old WIM
      wim_we = 1'b1; wim_in = 4'b0000; restore = 1'b1; tick();
      wim_we = 1'b0; restore = 1'b0;
      check("pre_wim_unf", unf_trap, 1);
      check("pre_wim_cwp", cwp, 3);
      check("pre_wim_val", wim, 0);

      // Wrap-around both directions
      restore = 1'b1; tick(); restore = 1'b0;
      check("wrap_up", cwp, 0);
      check("wrap_up_unf", unf_trap, 0);
      save = 1'b1; tick(); save = 1'b0;
      check("wrap_dn", cwp, 3);
      restore = 1'b1; tick(); restore = 1'b0;

      // save and restore together is a no-op
      save = 1'b1; restore = 1'b1; tick(); save = 1'b0; restore = 1'b0;
      check("both_cwp", cwp, 0);
      check("both_ovf", ovf_trap, 0);
      check("both_unf", unf_trap, 0);

      // Bypass forwarding
      LE = 1'b1; RW = 5'd5; RA = 5'd5; RB = 5'd6; PW = 32'hABCD; #1;
      check("byp_pa", PA, 32'hABCD);
      check("byp_pb_nomatch", PB, 0);
      RW = 5'd0; RA = 5'd0; #1;
      check("byp_r0", PA, 0);
      RW = 5'd5; tick(); LE = 1'b0;
      RA = 5'd5; #1;
      check("byp_stored", PA, 32'hABCD);

      // Asynchronous reset mid-operation
      RA = 5'd7; RB = 5'd5; RD = 5'd9;
      save = 1'b1; tick(); save = 1'b0;
      check("pre_rst_cwp", cwp, 3);
      check("pre_rst_r7", PA, 7);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cwp", cwp, 0);
      check("arst_wim", wim, 4'b1000);
      check("arst_r7", PA, 0);
      check("arst_r5", PB, 0);
      check("arst_r9", PD, 0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("post_rst_r7", PA, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
